// File: rtl/twos_comp_serializer.sv
// rtl/twos_comp_serializer.sv - parallel-in, serial-out LSB-first word serializer
//
// Purpose:
//   Accepts one WIDTH-bit word per load handshake and shifts it out one bit
//   per clock, LSB first. It drives the bit input of the downstream serial
//   two's-complement FSM. It produces word-boundary strobes so that FSM can
//   restart on every word.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   load_data  - word to serialize, sampled on an accepted load
//   load_valid - upstream presents a word
//   load_ready - block can accept a word this cycle
//   ser_bit    - current serial bit (LSB first)
//   ser_valid  - ser_bit carries a real data bit
//   ser_first  - cycle carrying bit 0 of a word
//   ser_last   - cycle carrying bit WIDTH-1 of a word
//   busy       - high while shifting
//
// Configuration macro:
//   TWOS_COMP_SERIALIZER_GAP_EN - when defined, no reload happens on the
//   last bit. One idle cycle then separates consecutive words.

module twos_comp_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;

  logic in_shift;
  logic is_last;
  logic accept;

  assign in_shift = (state == SHIFT);
  assign is_last  = in_shift && (cnt == LAST_IDX);

  // Ready depends only on state and reset. It never depends on load_valid,
  // so upstream can form its own valid from ready without a combinational loop.
`ifdef TWOS_COMP_SERIALIZER_GAP_EN
  assign load_ready = reset && !in_shift;
`else
  assign load_ready = reset && (!in_shift || is_last);
`endif

  assign accept = load_valid && load_ready;

  // All outputs decode from registers. An asynchronous reset therefore
  // clears them at once, without waiting for a clock edge.
  assign ser_bit   = in_shift && shreg[0];
  assign ser_valid = in_shift;
  assign busy      = in_shift;
  assign ser_first = in_shift && (cnt == '0);
  assign ser_last  = is_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      if (accept) begin
        // Covers both a fresh start from IDLE and a back-to-back reload on the last bit.
        shreg <= load_data;
        cnt   <= '0;
        state <= SHIFT;
      end else if (in_shift) begin
        shreg <= shreg >> 1;
        if (is_last) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_twos_comp_serializer.sv
// tb/tb_twos_comp_serializer.sv - randomized self-checking bench for twos_comp_serializer

module tb_twos_comp_serializer;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic [W-1:0] load_data;
  logic         load_valid;
  logic         load_ready;
  logic         ser_bit;
  logic         ser_valid;
  logic         ser_first;
  logic         ser_last;
  logic         busy;

  int checks = 0;
  int errors = 0;

  twos_comp_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .ser_bit    (ser_bit),
    .ser_valid  (ser_valid),
    .ser_first  (ser_first),
    .ser_last   (ser_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a queue of the bits still to be emitted, each tagged with its word-boundary flags.
  typedef struct packed {
    logic b;
    logic f;
    logic l;
  } sb_t;

  sb_t q[$];

  // Downstream two's-complement behaviour: copy bits up to and including the first 1, then invert.
  logic         tc_seen1;
  logic [W-1:0] tc_word;
  int           tc_idx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_ready();
`ifdef TWOS_COMP_SERIALIZER_GAP_EN
    return reset && (q.size() == 0);
`else
    return reset && (q.size() <= 1);
`endif
  endfunction

  // One clock of stimulus plus checks: drive at the negedge, compare outputs, then advance the model at the posedge.
  task automatic step(input logic v, input logic [W-1:0] d);
    sb_t exp;
    logic rdy;
    @(negedge clk);
    load_valid = v;
    load_data  = d;
    #1;
    exp = (q.size() != 0) ? q[0] : sb_t'(3'b000);
    rdy = model_ready();
    check("ser_bit",    ser_bit,    exp.b);
    check("ser_valid",  ser_valid,  q.size() != 0);
    check("busy",       busy,       q.size() != 0);
    check("ser_first",  ser_first,  exp.f);
    check("ser_last",   ser_last,   exp.l);
    check("load_ready", load_ready, rdy);
    if (ser_valid) begin
      if (ser_first) begin
        tc_seen1 = 1'b0;
        tc_idx   = 0;
        tc_word  = '0;
      end
      if (tc_idx < W) tc_word[tc_idx] = tc_seen1 ? ~ser_bit : ser_bit;
      if (ser_bit) tc_seen1 = 1'b1;
      tc_idx++;
    end
    @(posedge clk);
    if (q.size() != 0) void'(q.pop_front());
    if (v && rdy) begin
      for (int i = 0; i < W; i++) q.push_back('{d[i], i == 0, i == W - 1});
    end
  endtask

  initial begin
    reset      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    tc_seen1   = 1'b0;
    tc_word    = '0;
    tc_idx     = 0;
    #1;
    check("rst_ready", load_ready, 1'b0);
    check("rst_valid", ser_valid,  1'b0);
    check("rst_bit",   ser_bit,    1'b0);
    check("rst_busy",  busy,       1'b0);
    #9;
    reset = 1'b1;
    #1;
    check("post_rst_ready", load_ready, 1'b1);

    // Single word 0x1C, then the two's-complement result of the chain.
    step(1'b1, 8'h1C);
    for (int i = 0; i < W + 2; i++) step(1'b0, 8'h00);
    check("tc_word", tc_word, 8'hE4);

    // Held valid: 0x01, then 0x80.
    step(1'b1, 8'h01);
    for (int i = 0; i < W; i++) step(1'b1, 8'h80);
    for (int i = 0; i < W + 2; i++) step(1'b0, 8'h00);

    // 0xFF offered mid-word of 0xA5.
    step(1'b1, 8'hA5);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00);
    for (int i = 0; i < W; i++) step(1'b1, 8'hFF);
    for (int i = 0; i < W + 3; i++) step(1'b0, 8'h00);

    // Asynchronous reset during bit 4.
    step(1'b1, 8'hA5);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("amid_valid", ser_valid,  1'b0);
    check("amid_bit",   ser_bit,    1'b0);
    check("amid_first", ser_first,  1'b0);
    check("amid_last",  ser_last,   1'b0);
    check("amid_busy",  busy,       1'b0);
    check("amid_ready", load_ready, 1'b0);
    q.delete();
    @(posedge clk);
    #1;
    check("amid_hold_valid", ser_valid, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("release_ready", load_ready, 1'b1);
    for (int i = 0; i < W + 2; i++) step(1'b0, 8'h00);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 2) != 0, W'($urandom));
    end
    for (int i = 0; i < W + 3; i++) step(1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/twos_comp_serializer.md
Name: twos_comp_serializer

Overview:
- Parallel-in, serial-out LSB-first shifter. Sits directly upstream of the serial two's-complement FSM (TwosComp) and drives its bit input.
- Accepts one WIDTH-bit word per load handshake and emits it one bit per clock.
- Produces word-boundary strobes so the downstream FSM can restart per word.
- Output is gapless: the downstream stage consumes one bit every cycle and has no stall.

Parameters:
- WIDTH, 8, word width in bits; legal range 1..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- load_data  input  WIDTH  word to serialize; sampled only on an accepted load.
- load_valid  input  1  upstream has a word on load_data.
- load_ready  output  1  block can accept a word this cycle.
- ser_bit  output  1  current serial bit, LSB first; feeds TwosComp bit.
- ser_valid  output  1  ser_bit carries a real data bit this cycle.
- ser_first  output  1  high on the cycle carrying bit 0 of a word.
- ser_last  output  1  high on the cycle carrying bit WIDTH-1 of a word.
- busy  output  1  high while in SHIFT.

Behaviour:
- State: 2-state FSM {IDLE, SHIFT}, WIDTH-bit shift register shreg, bit counter cnt (max(1,$clog2(WIDTH)) bits).
- Reset (reset==0, asynchronous, any time including mid-word):
  - state=IDLE, shreg=0, cnt=0.
  - ser_bit=0, ser_valid=0, ser_first=0, ser_last=0, busy=0.
  - load_ready forced to 0 while reset==0.
  - A partial word in flight is discarded; nothing resumes after release.
- Output decode (from registers only, no combinational path from inputs except as noted):
  - ser_bit = shreg[0] when in SHIFT, else 0.
  - ser_valid = busy = (state==SHIFT).
  - ser_first = SHIFT && cnt==0.
  - ser_last = SHIFT && cnt==WIDTH-1.
- load_ready = reset && (state==IDLE || ser_last). Combinational from state only, never from load_valid.
- Load accept: load_valid && load_ready at a rising edge → shreg<=load_data, cnt<=0, state<=SHIFT.
- Latency: the word accepted at edge k has bit 0 on the outputs during the cycle after edge k, and bit WIDTH-1 exactly WIDTH-1 cycles later.
- SHIFT, not last: shreg<=shreg>>1, cnt<=cnt+1. A load_valid here is ignored because load_ready=0; upstream must hold its data.
- SHIFT, last cycle:
  - Accepted load → reload with the new word, stay in SHIFT, cnt<=0. This is back-to-back operation with no idle cycle.
  - No accepted load → state<=IDLE, cnt<=0.
- IDLE with load_valid=0: hold state; all serial outputs stay 0.
- WIDTH==1: every SHIFT cycle has ser_first and ser_last both high. Continuous loads give one word per cycle.
- Downstream usage: TwosComp is restarted at word boundaries by driving its restart from ser_first. The exact glue belongs to the top level, not this block.

Optional Feature:
- Macro: TWOS_COMP_SERIALIZER_GAP_EN.
- Defined:
  - load_ready = reset && state==IDLE only; no reload on the last cycle.
  - After every ser_last cycle the FSM always returns to IDLE, giving at least one cycle with ser_valid=0 between words.
  - This lets the top level use the gap cycle to pulse the downstream FSM reset.
- Undefined: back-to-back behaviour as described above.

Test Plan:
- Reset low 10ns, release, WIDTH=8, load 0x1C in one cycle → ser_bit sequence 0,0,1,1,1,0,0,0 on the 8 following cycles. ser_first only on cycle 1, ser_last only on cycle 8, ser_valid high for exactly 8 cycles, then IDLE with load_ready=1.
- load_valid held high with 0x01 then 0x80 presented → bits 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1 with no gap. load_ready high only on the two accept cycles; second ser_first on cycle 9.
- Assert load_valid with 0xFF during bit 3 of 0xA5 → ignored. The 0xA5 stream 1,0,1,0,0,1,0,1 completes unchanged; 0xFF is accepted on the ser_last cycle.
- Drop reset to 0 mid-cycle during bit 4 → all outputs 0 immediately, without waiting for a clock edge. After release: IDLE, load_ready=1, no residual bits emitted.
- Chain with TwosComp, feeding ser_bit into its bit input and ser_first into its restart, load 0x1C → collected output stream equals 0xE4 (0,0,1,0,0,1,1,1 LSB first).
- With TWOS_COMP_SERIALIZER_GAP_EN defined and load_valid held high → exactly one cycle with ser_valid=0 between consecutive words; word period is WIDTH+1 cycles.
